// File: rtl/fir_inverse_filter_if.sv
// Stream bundle for the inverse FIR: y samples in, recovered x samples out.
interface fir_inverse_filter_if;
  logic signed [15:0] y_in;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  x_out;
  logic               sat_out;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output y_in, in_valid, out_ready,
    input  in_ready, x_out, sat_out, out_valid
  );

  modport slave (
    input  y_in, in_valid, out_ready,
    output in_ready, x_out, sat_out, out_valid
  );
endinterface

// File: rtl/fir_inverse_filter.sv
// Recursive deconvolver for the 4-tap FIR: x[n] = (y[n] - sum Ck*x[n-k]) >>> C0_SHIFT,
// one shared serial multiplier, saturating 8-bit result fed back into history.
module fir_inverse_filter #(
  parameter int unsigned       C0_SHIFT = 1,
  parameter logic signed [7:0] C1       = 8'sd4,
  parameter logic signed [7:0] C2       = 8'sd4,
  parameter logic signed [7:0] C3       = 8'sd2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  fir_inverse_filter_if.slave  s
);

  typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} state_e;

  state_e             state_q, state_d;
  logic signed [19:0] acc_q, acc_d;
  logic [1:0]         tap_q, tap_d;
  logic signed [7:0]  h1_q, h1_d, h2_q, h2_d, h3_q, h3_d;
  logic signed [7:0]  x_q, x_d;
  logic               sat_q, sat_d;
  logic               vld_q, vld_d;

  logic signed [7:0]  coef, hist;
  logic signed [15:0] prod;
  logic signed [19:0] q;

  // Shared multiplier: tap counter selects which coefficient/history pair is in flight.
  always_comb begin
    case (tap_q)
      2'd1:    begin coef = C1; hist = h1_q; end
      2'd2:    begin coef = C2; hist = h2_q; end
      default: begin coef = C3; hist = h3_q; end
    endcase
    prod = coef * hist;
    q    = acc_q >>> C0_SHIFT;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    tap_d   = tap_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    h3_d    = h3_q;
    x_d     = x_q;
    sat_d   = sat_q;
    vld_d   = vld_q;

    case (state_q)
      IDLE: begin
        if (s.in_valid) begin
          acc_d   = {{4{s.y_in[15]}}, s.y_in};
          tap_d   = 2'd1;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q - {{4{prod[15]}}, prod};
        tap_d = tap_q + 2'd1;
        if (tap_q == 2'd3) begin
          tap_d   = 2'd0;
          state_d = SCALE;
        end
      end
      SCALE: begin
        if (q > 20'sd127) begin
          x_d   = 8'sd127;
          sat_d = 1'b1;
        end else if (q < -20'sd128) begin
          x_d   = -8'sd128;
          sat_d = 1'b1;
        end else begin
          x_d   = q[7:0];
          sat_d = 1'b0;
        end
        // The clamped value, not q, is what the recursion sees next time.
        h3_d    = h2_q;
        h2_d    = h1_q;
        h1_d    = x_d;
        vld_d   = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (s.out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // x_out deliberately survives a flush so downstream still sees the last sample.
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      tap_d   = 2'd0;
      h1_d    = '0;
      h2_d    = '0;
      h3_d    = '0;
      sat_d   = 1'b0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      tap_q   <= 2'd0;
      h1_q    <= '0;
      h2_q    <= '0;
      h3_q    <= '0;
      x_q     <= '0;
      sat_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tap_q   <= tap_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      h3_q    <= h3_d;
      x_q     <= x_d;
      sat_q   <= sat_d;
      vld_q   <= vld_d;
    end
  end

  assign s.in_ready  = (state_q == IDLE);
  assign s.x_out     = x_q;
  assign s.sat_out   = sat_q;
  assign s.out_valid = vld_q;

endmodule

// File: tb/tb_fir_inverse_filter.sv
// Randomized and directed check of fir_inverse_filter against an integer recursion model.
module tb_fir_inverse_filter;
  localparam int K0 = 1;
  localparam int K1 = 4;
  localparam int K2 = 4;
  localparam int K3 = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  fir_inverse_filter_if bus ();

  fir_inverse_filter #(
    .C0_SHIFT(K0), .C1(8'(K1)), .C2(8'(K2)), .C3(8'(K3))
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .s(bus)
  );

  int errors = 0;
  int checks = 0;
  int hist[3];

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor_div(input int a, input int d);
    int r = a / d;
    if ((a % d) != 0 && a < 0) r = r - 1;
    return r;
  endfunction

  task automatic model_clear();
    hist = '{0, 0, 0};
  endtask

  task automatic model_step(input int y, output int x, output int sat);
    int acc, qq;
    acc = y - K1 * hist[0] - K2 * hist[1] - K3 * hist[2];
    qq  = floor_div(acc, 2 ** K0);
    sat = (qq > 127 || qq < -128) ? 1 : 0;
    x   = (qq > 127) ? 127 : (qq < -128) ? -128 : qq;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = x;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_rdy", bus.in_ready, 1);
    chk("rst_x", bus.x_out, 0);
    chk("rst_sat", bus.sat_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // Push one sample through; garbage drives in_valid with gy while busy.
  task automatic do_sample(input int y, input int stall, input bit garbage, input int gy, output int xo);
    int n, ex, es;
    bus.y_in      = 16'(y);
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    n = 0;
    while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = garbage;
    bus.y_in     = 16'(gy);
    n = 0;
    while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", n, 4);
    chk("busy_rdy", bus.in_ready, 0);
    model_step(y, ex, es);
    chk("x_out", bus.x_out, ex);
    chk("sat_out", bus.sat_out, es);
    xo = int'(bus.x_out);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_x", bus.x_out, ex);
      chk("hold_rdy", bus.in_ready, 0);
    end
    if (stall > 0) chk("hold_vld", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("drain_vld", bus.out_valid, 0);
    chk("drain_rdy", bus.in_ready, 1);
  endtask

  initial begin
    int xo;
    int t1y[9] = '{2, 4, 4, 2, 0, 6, 8, 14, -238};
    int t1x[9] = '{1, 0, 0, 0, 0, 3, -2, 5, -128};
    bus.y_in = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    model_clear();
    #2;
    do_reset();

    // Impulse followed by the mixed sequence (history carries over).
    foreach (t1y[i]) begin
      do_sample(t1y[i], 0, 1'b0, 0, xo);
      chk("seq_lit", xo, t1x[i]);
      chk("seq_sat", bus.sat_out, 0);
    end

    // Saturation both ways, with clamped value feeding the next sample.
    do_reset();
    do_sample(300, 0, 1'b0, 0, xo);
    chk("sat_hi", xo, 127);
    do_sample(0, 0, 1'b0, 0, xo);
    chk("sat_lo", xo, -128);

    // Floor rounding on odd inputs.
    do_reset();
    do_sample(-3, 0, 1'b0, 0, xo);
    chk("floor_neg", xo, -2);
    do_reset();
    do_sample(3, 0, 1'b0, 0, xo);
    chk("floor_pos", xo, 1);

    // Backpressure: 10 stalled cycles with a competing y=100 that must not be taken.
    do_sample(6, 10, 1'b1, 100, xo);
    do_sample(0, 0, 1'b0, 0, xo);

    // Reset during the second MAC cycle.
    bus.y_in = 16'(50); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("abort_vld", bus.out_valid, 0);
    chk("abort_rdy", bus.in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();

    // clear between samples flushes history.
    do_sample(2, 0, 1'b0, 0, xo);
    chk("pre_clear", xo, 1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    do_sample(4, 0, 1'b0, 0, xo);
    chk("post_clear", xo, 2);

    // clear mid-MAC aborts the sample but keeps x_out.
    bus.y_in = 16'(40); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    chk("clr_vld", bus.out_valid, 0);
    chk("clr_rdy", bus.in_ready, 1);
    chk("clr_x", bus.x_out, 2);

    // Random traffic with stalls and ignored busy-time inputs.
    for (int i = 0; i < 60; i++) begin
      int y;
      if ($urandom_range(0, 4) == 0) y = int'($signed(16'($urandom)));
      else y = int'($urandom_range(0, 1023)) - 512;
      do_sample(y, int'($urandom_range(0, 3)), 1'($urandom), int'($urandom), xo);
      if ($urandom_range(0, 15) == 0) begin
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_clear();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
